pip_exu_issue_fifo: RTL and testbench

//  Parametrised issue buffer between the dispatch stage and one execution unit (ALU/BRU/MDIV/LSU).

---
 rtl/pip_exu_issue_fifo.sv | 113 +++++++++++
 tb/tb_pip_exu_issue_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pip_exu_issue_fifo.sv
// In-order issue FIFO between dispatch and one EXU, with valid/full handshakes and a pipeline flush.
// Optional same-cycle bypass on an empty FIFO is enabled by defining PIP_EXU_BYPASS_EN.
module pip_exu_issue_fifo #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int ITAG_W = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_full_o,
  input  logic [XLEN-1:0]            in_data1_i,
  input  logic [XLEN-1:0]            in_data2_i,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [19:0]                in_imm20_i,
  input  logic [4:0]                 in_opcode_i,
  input  logic [9:0]                 in_funct_i,
  input  logic [ITAG_W-1:0]          in_itag_i,
  output logic                       out_valid_o,
  input  logic                       out_full_i,
  output logic [XLEN-1:0]            out_data1_o,
  output logic [XLEN-1:0]            out_data2_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [19:0]                out_imm20_o,
  output logic [4:0]                 out_opcode_o,
  output logic [9:0]                 out_funct_o,
  output logic [ITAG_W-1:0]          out_itag_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PL_W  = 3 * XLEN + 20 + 5 + 10 + ITAG_W;

  logic [PL_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             empty_s;
  logic             full_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic [PL_W-1:0]  in_pl_s;
  logic [PL_W-1:0]  out_pl_s;

  assign in_pl_s = {in_data1_i, in_data2_i, in_pc_i, in_imm20_i, in_opcode_i, in_funct_i, in_itag_i};
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == CNT_W'(DEPTH));

`ifdef PIP_EXU_BYPASS_EN
  // A bypassed entry is consumed by the EXU directly and never occupies a slot.
  assign bypass_s = empty_s & in_valid_i & ~out_full_i & ~flush_i;
`else
  assign bypass_s = 1'b0;
`endif

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign push_s = in_valid_i & ~full_s & ~bypass_s;
  assign pop_s  = ~empty_s & ~out_full_i;

  // Pointer and occupancy state; flush overrides any concurrent push or pop.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage is deliberately left unreset; the output mux hides stale slots.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      mem_r[wr_ptr_r] <= in_pl_s;
    end
  end

  // Head payload selection: bypass, stored head, or zero when nothing is valid.
  always_comb begin
    out_pl_s = {PL_W{1'b0}};
    if (bypass_s) begin
      out_pl_s = in_pl_s;
    end else if (!empty_s) begin
      out_pl_s = mem_r[rd_ptr_r];
    end else begin
      out_pl_s = {PL_W{1'b0}};
    end
  end

  assign {out_data1_o, out_data2_o, out_pc_o, out_imm20_o, out_opcode_o, out_funct_o, out_itag_o} = out_pl_s;
  assign out_valid_o = ~empty_s | bypass_s;
  assign in_full_o   = full_s;
  assign count_o     = count_r;

endmodule

// File: tb/tb_pip_exu_issue_fifo.sv
// Self-checking bench for pip_exu_issue_fifo: vector table, directed corners and a queue-based random model.
// Honours PIP_EXU_BYPASS_EN in both the model and the directed bypass sequence.
module tb_pip_exu_issue_fifo;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 4;
  localparam int ITAG_W = 8;
  localparam int CNT_W  = 3;
  localparam int NVEC   = 21;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] pc;
    logic [19:0] imm;
    logic [4:0]  opc;
    logic [9:0]  fn;
    logic [7:0]  itag;
  } pl_t;

  typedef struct {
    logic       fl;
    logic       iv;
    logic       of;
    logic [7:0] itag;
    logic [2:0] cnt;
    logic       v;
    logic       f;
    logic [7:0] eitag;
  } vec_t;

  logic             clk;
  logic             arst_n;
  logic             flush;
  logic             in_valid;
  logic             out_full;
  pl_t              in_pl;
  logic             in_full;
  logic             out_valid;
  logic [63:0]      out_d1, out_d2, out_pc;
  logic [19:0]      out_imm;
  logic [4:0]       out_opc;
  logic [9:0]       out_fn;
  logic [7:0]       out_itag;
  logic [CNT_W-1:0] count;

  int               checks;
  int               errors;
  pl_t              q[$];
  logic [7:0]       out_seen[$];
  logic             last_acc;
  logic [CNT_W-1:0] max_cnt;
  vec_t             tbl[NVEC];

  pip_exu_issue_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .ITAG_W(ITAG_W)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_full_o(in_full),
    .in_data1_i(in_pl.d1), .in_data2_i(in_pl.d2), .in_pc_i(in_pl.pc),
    .in_imm20_i(in_pl.imm), .in_opcode_i(in_pl.opc), .in_funct_i(in_pl.fn), .in_itag_i(in_pl.itag),
    .out_valid_o(out_valid), .out_full_i(out_full),
    .out_data1_o(out_d1), .out_data2_o(out_d2), .out_pc_o(out_pc),
    .out_imm20_o(out_imm), .out_opcode_o(out_opc), .out_funct_o(out_fn), .out_itag_o(out_itag),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pl_t mk_pl(input logic [7:0] tag);
    pl_t p;
    p.d1   = {$urandom, $urandom};
    p.d2   = {$urandom, $urandom};
    p.pc   = {$urandom, $urandom};
    p.imm  = 20'($urandom);
    p.opc  = 5'($urandom);
    p.fn   = 10'($urandom);
    p.itag = tag;
    return p;
  endfunction

  // Drive one cycle's inputs, compare DUT outputs to the queue model before the edge, then advance the model.
  task automatic apply(input logic fl, input logic iv, input logic of, input pl_t p);
    logic byp;
    logic acc;
    pl_t  exp_pl;
    @(negedge clk);
    flush = fl; in_valid = iv; out_full = of; in_pl = p;
    #1;
    byp = 1'b0;
`ifdef PIP_EXU_BYPASS_EN
    byp = (q.size() == 0) && iv && !of && !fl;
`endif
    if (byp) exp_pl = p;
    else if (q.size() != 0) exp_pl = q[0];
    else exp_pl = '0;
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_valid", 64'(out_valid), 64'((q.size() != 0) || byp));
    chk("m_full", 64'(in_full), 64'(q.size() == DEPTH));
    chk("m_itag", 64'(out_itag), 64'(exp_pl.itag));
    chk("m_data1", out_d1, exp_pl.d1);
    chk("m_data2", out_d2, exp_pl.d2);
    chk("m_pc", out_pc, exp_pl.pc);
    chk("m_misc", 64'({out_imm, out_opc, out_fn}), 64'({exp_pl.imm, exp_pl.opc, exp_pl.fn}));
    if (count > max_cnt) max_cnt = count;
    acc = iv && (q.size() < DEPTH) && !byp && !fl;
    last_acc = acc || byp;
    if (fl) begin
      q.delete();
      last_acc = 1'b0;
    end else begin
      if (q.size() != 0 && !of) out_seen.push_back(q.pop_front().itag);
      else if (byp) out_seen.push_back(p.itag);
      if (acc) q.push_back(p);
    end
  endtask

  initial begin
    checks = 0; errors = 0; max_cnt = '0; last_acc = 1'b0;
    arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_full = 1'b0; in_pl = '0;

    //          fl    iv    of    itag    cnt   v     f     eitag
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0, 8'h01};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h03, 3'd2, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h04, 3'd3, 1'b1, 1'b0, 8'h01};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h05, 3'd4, 1'b1, 1'b1, 8'h01};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h05, 3'd4, 1'b1, 1'b1, 8'h01};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'h02};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0, 8'h03};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 8'h04};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h12, 3'd1, 1'b1, 1'b0, 8'h11};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h13, 3'd2, 1'b1, 1'b0, 8'h11};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h14, 3'd3, 1'b1, 1'b0, 8'h11};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h22, 3'd4, 1'b1, 1'b1, 8'h11};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1, 1'b0, 8'h12};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 1'b1, 1'b1, 8'h12};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 1'b1, 8'h12};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 8'h7F, 3'd3, 1'b1, 1'b0, 8'h13};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};

    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_full", 64'(in_full), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_itag", 64'(out_itag), 64'(0));
    #11 arst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].fl, tbl[i].iv, tbl[i].of, mk_pl(tbl[i].itag));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_full", i), 64'(in_full), 64'(tbl[i].f));
      chk($sformatf("tbl%0d_itag", i), 64'(out_itag), 64'(tbl[i].eitag));
    end

    // Wrap: ten entries through a four-deep FIFO with back-pressure toggling every 3 cycles.
    begin
      int nxt;
      nxt = 0;
      out_seen.delete();
      max_cnt = '0;
      for (int c = 0; c < 100 && out_seen.size() < 10; c++) begin
        apply(1'b0, nxt < 10, ((c / 3) % 2) == 1, mk_pl(8'(nxt)));
        if (last_acc) nxt++;
      end
      chk("wrap_out_count", 64'(out_seen.size()), 64'(10));
      for (int i = 0; i < out_seen.size(); i++) chk($sformatf("wrap_order%0d", i), 64'(out_seen[i]), 64'(i));
      chk("wrap_max_le4", 64'(max_cnt <= 3'd4), 64'(1));
    end
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, '0);

    // Empty-FIFO push with no back-pressure: same-cycle with bypass, one cycle later without.
    begin
      pl_t p;
      p = mk_pl(8'h10);
      p.d1 = 64'hDEAD;
      apply(1'b0, 1'b1, 1'b0, p);
`ifdef PIP_EXU_BYPASS_EN
      chk("byp_valid0", 64'(out_valid), 64'(1));
      chk("byp_itag0", 64'(out_itag), 64'h10);
      chk("byp_data1", out_d1, 64'hDEAD);
      chk("byp_count0", 64'(count), 64'(0));
      apply(1'b0, 1'b0, 1'b1, mk_pl(8'h00));
      chk("byp_valid1", 64'(out_valid), 64'(0));
      chk("byp_count1", 64'(count), 64'(0));
`else
      chk("nobyp_valid0", 64'(out_valid), 64'(0));
      chk("nobyp_count0", 64'(count), 64'(0));
      apply(1'b0, 1'b0, 1'b1, mk_pl(8'h00));
      chk("nobyp_valid1", 64'(out_valid), 64'(1));
      chk("nobyp_count1", 64'(count), 64'(1));
      chk("nobyp_itag1", 64'(out_itag), 64'h10);
      chk("nobyp_data1", out_d1, 64'hDEAD);
`endif
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, '0);
    end

    // Asynchronous reset with entries held: outputs must clear before any clock edge.
    apply(1'b0, 1'b1, 1'b1, mk_pl(8'h31));
    apply(1'b0, 1'b1, 1'b1, mk_pl(8'h32));
    apply(1'b0, 1'b0, 1'b1, '0);
    arst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_full", 64'(in_full), 64'(0));
    chk("arst_itag", 64'(out_itag), 64'(0));
    chk("arst_data1", out_d1, 64'(0));
    q.delete();
    #1 arst_n = 1'b1;

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            mk_pl(8'($urandom)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
